// File: rtl/mc_array_model.sv
// ============================================================================
// Module   : mc_array_model
// Purpose  : DRAM bank array storage model with fixed-latency read return,
//            saturating access counters and optional protocol checking
//            (enabled by defining ARRAY_PROTO_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_array_model #(
    parameter int RADDR_WIDTN = 14,
    parameter int CADDR_WIDTH = 6,
    parameter int DATA_WIDTH  = 64,
    parameter int ROW_USED    = 6,
    parameter int RD_LAT      = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   array_banksel_n,
    input  logic [RADDR_WIDTN-1:0] array_raddr,
    input  logic                   array_cas_wr,
    input  logic [CADDR_WIDTH-1:0] array_caddr_wr,
    input  logic                   array_cas_rd,
    input  logic [CADDR_WIDTH-1:0] array_caddr_rd,
    input  logic                   array_wdata_rdy,
    input  logic [DATA_WIDTH-1:0]  array_wdata,
    output logic                   array_rdata_rdy,
    output logic [DATA_WIDTH-1:0]  array_rdata,
    output logic [CNT_WIDTH-1:0]   wr_cnt,
    output logic [CNT_WIDTH-1:0]   rd_cnt,
    output logic                   proto_err,
    output logic [2:0]             err_code
);

    localparam int IDX_W = ROW_USED + CADDR_WIDTH;
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_CLOSED = 1'b0;
    localparam logic [0:0] ST_OPEN   = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [0:0]             state_q, state_d;
    logic                   row_open;
    logic [RADDR_WIDTN-1:0] open_row_q, open_row_d;
    logic                   wr_acc, rd_acc;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [RD_LAT-1:0]      vld_q, vld_d;
    logic [DATA_WIDTH-1:0]  dat_q [RD_LAT];
    logic [DATA_WIDTH-1:0]  dat_d [RD_LAT];
    logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;

    // Row FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_CLOSED;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            open_row_q <= open_row_d;
        end
    end

    // Row FSM: next state; the row address is captured only on the opening edge
    always_comb begin
        state_d    = state_q;
        open_row_d = open_row_q;
        case (state_q)
            ST_CLOSED: begin
                if (!array_banksel_n) begin
                    state_d    = ST_OPEN;
                    open_row_d = array_raddr;
                end
            end
            ST_OPEN: begin
                if (array_banksel_n) begin
                    state_d = ST_CLOSED;
                end
            end
        endcase
    end

    // Row FSM: outputs
    always_comb begin
        row_open = (state_q == ST_OPEN);
    end

    assign wr_acc  = row_open && array_cas_wr && array_wdata_rdy;
    assign rd_acc  = row_open && array_cas_rd;
    assign wr_idx  = {open_row_q[ROW_USED-1:0], array_caddr_wr};
    assign rd_idx  = {open_row_q[ROW_USED-1:0], array_caddr_rd};

    // Read samples the array before this edge's write lands: read-before-write
    assign rd_word = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_idx] <= array_wdata;
        end
    end

    // Data stages only advance with a valid entry so the output holds between pulses
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = rd_acc;
        dat_d[0] = rd_acc ? rd_word : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_comb begin
        wr_cnt_d = (wr_acc && (wr_cnt_q != '1)) ? wr_cnt_q + CNT_ONE : wr_cnt_q;
        rd_cnt_d = (rd_acc && (rd_cnt_q != '1)) ? rd_cnt_q + CNT_ONE : rd_cnt_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            dat_q    <= dat_d;
        end
    end

    assign array_rdata_rdy = vld_q[RD_LAT-1];
    assign array_rdata     = dat_q[RD_LAT-1];
    assign wr_cnt          = wr_cnt_q;
    assign rd_cnt          = rd_cnt_q;

`ifdef ARRAY_PROTO_CHECK_EN
    logic [2:0] err_code_q, err_code_d;

    always_comb begin
        err_code_d = err_code_q;
        if ((array_cas_wr || array_cas_rd) && !row_open) begin
            err_code_d[0] = 1'b1;
        end
        if (row_open && !array_banksel_n && (array_raddr != open_row_q)) begin
            err_code_d[1] = 1'b1;
        end
        if (array_cas_wr && (!array_wdata_rdy || array_cas_rd)) begin
            err_code_d[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_code_q <= '0;
        end else begin
            err_code_q <= err_code_d;
        end
    end

    assign err_code  = err_code_q;
    assign proto_err = |err_code_q;
`else
    // Upper row bits only feed the protocol checker
    logic unused_row_hi;
    assign unused_row_hi = ^open_row_q;
    assign err_code      = 3'b000;
    assign proto_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_array_model.sv
// ============================================================================
// Module   : tb_mc_array_model
// Purpose  : Self-checking bench for mc_array_model (vector table plus
//            multi-cycle reset, dropped-write and saturation sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_array_model;

    localparam int CNT_W = 4;

    logic              clk;
    logic              rstn;
    logic              banksel_n;
    logic [13:0]       raddr;
    logic              cas_wr;
    logic [5:0]        caddr_wr;
    logic              cas_rd;
    logic [5:0]        caddr_rd;
    logic              wdata_rdy;
    logic [63:0]       wdata;
    logic              rdata_rdy;
    logic [63:0]       rdata;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic              proto_err;
    logic [2:0]        err_code;

    int n_cmp = 0;
    int n_bad = 0;

    mc_array_model #(
        .RADDR_WIDTN (14),
        .CADDR_WIDTH (6),
        .DATA_WIDTH  (64),
        .ROW_USED    (6),
        .RD_LAT      (2),
        .CNT_WIDTH   (CNT_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .array_banksel_n (banksel_n),
        .array_raddr     (raddr),
        .array_cas_wr    (cas_wr),
        .array_caddr_wr  (caddr_wr),
        .array_cas_rd    (cas_rd),
        .array_caddr_rd  (caddr_rd),
        .array_wdata_rdy (wdata_rdy),
        .array_wdata     (wdata),
        .array_rdata_rdy (rdata_rdy),
        .array_rdata     (rdata),
        .wr_cnt          (wr_cnt),
        .rd_cnt          (rd_cnt),
        .proto_err       (proto_err),
        .err_code        (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bs_n;
        logic [13:0] ra;
        logic        wr;
        logic        rd;
        logic [5:0]  col;
        logic [63:0] wd;
        logic        e_rdy;
        logic [63:0] e_rdata;
        logic [3:0]  e_wc;
        logic [3:0]  e_rc;
        logic [2:0]  e_err;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    function automatic logic [2:0] exp_err(input logic [2:0] e);
`ifdef ARRAY_PROTO_CHECK_EN
        return e;
`else
        return 3'b000;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic bs, input logic [13:0] ra,
                        input logic wr, input logic rd, input logic [5:0] col,
                        input logic [63:0] wd, input logic rdy, input logic [63:0] rdat,
                        input logic [3:0] wc, input logic [3:0] rc, input logic [2:0] err);
        vecs[i].bs_n    = bs;
        vecs[i].ra      = ra;
        vecs[i].wr      = wr;
        vecs[i].rd      = rd;
        vecs[i].col     = col;
        vecs[i].wd      = wd;
        vecs[i].e_rdy   = rdy;
        vecs[i].e_rdata = rdat;
        vecs[i].e_wc    = wc;
        vecs[i].e_rc    = rc;
        vecs[i].e_err   = err;
    endtask

    task automatic drive(input logic bs, input logic [13:0] ra, input logic wr,
                         input logic wrdy, input logic rd, input logic [5:0] col,
                         input logic [63:0] wd);
        banksel_n = bs;
        raddr     = ra;
        cas_wr    = wr;
        wdata_rdy = wrdy;
        cas_rd    = rd;
        caddr_wr  = col;
        caddr_rd  = col;
        wdata     = wd;
    endtask

    task automatic chk_state(input string nm, input logic rdy, input logic [63:0] rdat,
                             input logic [3:0] wc, input logic [3:0] rc, input logic [2:0] err);
        chk({nm, " rdy"},   64'(rdata_rdy), 64'(rdy));
        chk({nm, " rdata"}, rdata, rdat);
        chk({nm, " wr_cnt"}, 64'(wr_cnt), 64'(wc));
        chk({nm, " rd_cnt"}, 64'(rd_cnt), 64'(rc));
        chk({nm, " err_code"}, 64'(err_code), 64'(exp_err(err)));
        chk({nm, " proto_err"}, 64'(proto_err), 64'(|exp_err(err)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // bs_n ra wr rd col wdata | rdy rdata wc rc err
        setv( 0, 0, 14'h03, 0, 0, 0, 0,        0, 0,       0, 0, 3'b000);
        setv( 1, 0, 14'h03, 1, 0, 5, 64'd1010, 0, 0,       0, 0, 3'b000);
        setv( 2, 0, 14'h03, 0, 1, 5, 0,        0, 0,       1, 0, 3'b000);
        setv( 3, 0, 14'h03, 0, 0, 0, 0,        0, 0,       1, 1, 3'b000);
        setv( 4, 0, 14'h03, 1, 0, 0, 64'd1010, 1, 64'd1010, 1, 1, 3'b000);
        setv( 5, 0, 14'h03, 1, 0, 1, 64'd1011, 0, 64'd1010, 2, 1, 3'b000);
        setv( 6, 0, 14'h03, 1, 0, 2, 64'd1012, 0, 64'd1010, 3, 1, 3'b000);
        setv( 7, 0, 14'h03, 1, 0, 3, 64'd1013, 0, 64'd1010, 4, 1, 3'b000);
        setv( 8, 0, 14'h03, 0, 1, 0, 0,        0, 64'd1010, 5, 1, 3'b000);
        setv( 9, 0, 14'h03, 0, 1, 1, 0,        0, 64'd1010, 5, 2, 3'b000);
        setv(10, 0, 14'h03, 0, 1, 2, 0,        1, 64'd1010, 5, 3, 3'b000);
        setv(11, 0, 14'h03, 0, 1, 3, 0,        1, 64'd1011, 5, 4, 3'b000);
        setv(12, 0, 14'h03, 0, 0, 0, 0,        1, 64'd1012, 5, 5, 3'b000);
        setv(13, 0, 14'h03, 0, 0, 0, 0,        1, 64'd1013, 5, 5, 3'b000);
        setv(14, 1, 14'h03, 0, 0, 0, 0,        0, 64'd1013, 5, 5, 3'b000);
        setv(15, 1, 14'h03, 0, 1, 5, 0,        0, 64'd1013, 5, 5, 3'b000);
        setv(16, 1, 14'h03, 0, 0, 0, 0,        0, 64'd1013, 5, 5, 3'b001);
        setv(17, 0, 14'h41, 0, 0, 0, 0,        0, 64'd1013, 5, 5, 3'b001);
        setv(18, 0, 14'h41, 1, 0, 2, 64'hAA,   0, 64'd1013, 5, 5, 3'b001);
        setv(19, 1, 14'h41, 0, 0, 0, 0,        0, 64'd1013, 6, 5, 3'b001);
        setv(20, 0, 14'h01, 0, 0, 0, 0,        0, 64'd1013, 6, 5, 3'b001);
        setv(21, 0, 14'h01, 0, 1, 2, 0,        0, 64'd1013, 6, 5, 3'b001);
        setv(22, 0, 14'h01, 0, 0, 0, 0,        0, 64'd1013, 6, 6, 3'b001);
        setv(23, 0, 14'h01, 1, 0, 7, 64'h11,   1, 64'hAA,   6, 6, 3'b001);
        setv(24, 0, 14'h01, 1, 1, 7, 64'h22,   0, 64'hAA,   7, 6, 3'b001);
        setv(25, 0, 14'h01, 0, 0, 0, 0,        0, 64'hAA,   8, 7, 3'b101);
        setv(26, 0, 14'h01, 0, 1, 7, 0,        1, 64'h11,   8, 7, 3'b101);
        setv(27, 0, 14'h01, 0, 0, 0, 0,        0, 64'h11,   8, 8, 3'b101);
        setv(28, 1, 14'h01, 0, 0, 0, 0,        1, 64'h22,   8, 8, 3'b101);
        setv(29, 0, 14'h03, 0, 0, 0, 0,        0, 64'h22,   8, 8, 3'b101);
        setv(30, 0, 14'h04, 0, 0, 0, 0,        0, 64'h22,   8, 8, 3'b101);
        setv(31, 0, 14'h04, 0, 1, 5, 0,        0, 64'h22,   8, 8, 3'b111);
        setv(32, 0, 14'h04, 0, 0, 0, 0,        0, 64'h22,   8, 9, 3'b111);
        setv(33, 0, 14'h04, 0, 0, 0, 0,        1, 64'd1010, 8, 9, 3'b111);

        rstn = 1'b0;
        drive(1'b1, 14'h0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk_state($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_rdata,
                      vecs[i].e_wc, vecs[i].e_rc, vecs[i].e_err);
            drive(vecs[i].bs_n, vecs[i].ra, vecs[i].wr, vecs[i].wr,
                  vecs[i].rd, vecs[i].col, vecs[i].wd);
        end

        // Reset one cycle after an accepted read: in-flight data must vanish
        @(negedge clk);
        drive(1'b0, 14'h03, 1'b0, 1'b0, 1'b1, 6'd5, 64'd0);
        @(negedge clk);
        drive(1'b0, 14'h03, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
        rstn = 1'b0;
        #1;
        chk_state("rst_mid", 1'b0, 64'd0, 4'd0, 4'd0, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_rdy%0d", i), 64'(rdata_rdy), 64'd0);
        end
        drive(1'b0, 14'h03, 1'b0, 1'b0, 1'b1, 6'd5, 64'd0);
        @(negedge clk);
        drive(1'b0, 14'h03, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
        chk_state("rst_rd_issue", 1'b0, 64'd0, 4'd0, 4'd1, 3'b000);
        @(negedge clk);
        chk_state("rst_rd_data", 1'b1, 64'd1010, 4'd0, 4'd1, 3'b000);

        // Write strobe without data valid is dropped
        drive(1'b0, 14'h03, 1'b1, 1'b0, 1'b0, 6'd5, 64'd5555);
        @(negedge clk);
        drive(1'b0, 14'h03, 1'b0, 1'b0, 1'b1, 6'd5, 64'd0);
        chk_state("drop_wr", 1'b0, 64'd1010, 4'd0, 4'd1, 3'b100);
        @(negedge clk);
        drive(1'b0, 14'h03, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
        @(negedge clk);
        chk_state("drop_wr_rd", 1'b1, 64'd1010, 4'd0, 4'd2, 3'b100);

        // Write counter saturates at all-ones
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 14'h03, 1'b1, 1'b1, 1'b0, 6'd10, 64'(i));
            @(negedge clk);
        end
        drive(1'b0, 14'h03, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
        @(negedge clk);
        chk("wr_cnt_sat", 64'(wr_cnt), 64'd15);
        chk("rd_cnt_hold", 64'(rd_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
